// File: rtl/ecc_scalar_ctrl.sv
// ecc_scalar_ctrl
// Double-and-add sequencer for ECC scalar multiplication. It walks the scalar
// MSB-first and keeps the accumulator point R together with its
// point-at-infinity flag. Each double or add is handed to an external
// point-arithmetic unit through a start/done handshake.
// A double or add on an infinite R is never sent to the unit: doubling
// infinity is skipped, and adding P to infinity simply loads R with P.
module ecc_scalar_ctrl #(
    parameter int WIDTH = 4,
    parameter int KBITS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KBITS-1:0] k,
    input  logic [WIDTH-1:0] Px,
    input  logic [WIDTH-1:0] Py,
    output logic             op_start,
    output logic             op_dbl,
    output logic [WIDTH-1:0] op_x1,
    output logic [WIDTH-1:0] op_y1,
    output logic [WIDTH-1:0] op_x2,
    output logic [WIDTH-1:0] op_y2,
    input  logic             op_done,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             op_inf,
    output logic [WIDTH-1:0] kPx,
    output logic [WIDTH-1:0] kPy,
    output logic             kP_inf,
    output logic             busy,
    output logic             done
);

    // state    | meaning
    // IDLE     | waiting for i_start; operands are latched on acceptance
    // DBL      | double step for the current bit; skipped while R is infinity
    // DBL_WAIT | double outstanding; R is captured on op_done
    // ADD      | add step; runs only when the current scalar bit is 1
    // ADD_WAIT | add outstanding; R is captured on op_done
    // NEXT     | move to the next lower bit, or finish after bit 0
    // DONE     | one-cycle completion pulse; kP is already visible
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DBL      = 3'd1;
    localparam logic [2:0] S_DBL_WAIT = 3'd2;
    localparam logic [2:0] S_ADD      = 3'd3;
    localparam logic [2:0] S_ADD_WAIT = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int              IDXW    = (KBITS > 1) ? $clog2(KBITS) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(KBITS - 1);

    logic [2:0]       state;
    logic [KBITS-1:0] ks;
    logic [WIDTH-1:0] ps_x;
    logic [WIDTH-1:0] ps_y;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_inf;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] kp_x;
    logic [WIDTH-1:0] kp_y;
    logic             kp_inf;
    logic             bit_set;

    assign bit_set = ks[idx];

    // Moore outputs: an operation is issued only on the first cycle of DBL/ADD,
    // and only when R is a finite point.
    assign op_start = ~r_inf & ((state == S_DBL) | ((state == S_ADD) & bit_set));
    assign op_dbl   = (state == S_DBL);
    assign op_x1    = r_x;
    assign op_y1    = r_y;
    assign op_x2    = ps_x;
    assign op_y2    = ps_y;
    assign kPx      = kp_x;
    assign kPy      = kp_y;
    assign kP_inf   = kp_inf;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // Sequencer state, latched operands, accumulator and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            ks     <= '0;
            ps_x   <= '0;
            ps_y   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_inf  <= 1'b1;
            idx    <= IDX_TOP;
            kp_x   <= '0;
            kp_y   <= '0;
            kp_inf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        ks    <= k;
                        ps_x  <= Px;
                        ps_y  <= Py;
                        r_inf <= 1'b1;
                        idx   <= IDX_TOP;
                        state <= S_DBL;
                    end
                end
                S_DBL: begin
                    state <= r_inf ? S_ADD : S_DBL_WAIT;
                end
                S_DBL_WAIT: begin
                    if (op_done) begin
                        r_x   <= op_x;
                        r_y   <= op_y;
                        r_inf <= op_inf;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (!bit_set) begin
                        state <= S_NEXT;
                    end else if (r_inf) begin
                        r_x   <= ps_x;
                        r_y   <= ps_y;
                        r_inf <= 1'b0;
                        state <= S_NEXT;
                    end else begin
                        state <= S_ADD_WAIT;
                    end
                end
                S_ADD_WAIT: begin
                    if (op_done) begin
                        r_x   <= op_x;
                        r_y   <= op_y;
                        r_inf <= op_inf;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == '0) begin
                        // Result is loaded on entry so it is already valid
                        // during the done pulse.
                        kp_x   <= r_inf ? '0 : r_x;
                        kp_y   <= r_inf ? '0 : r_y;
                        kp_inf <= r_inf;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx - IDXW'(1);
                        state <= S_DBL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scalar_ctrl.sv
// Bench for ecc_scalar_ctrl. It contains a behavioural point unit with
// latency 3 over y^2 = x^3 + 2x + 3 mod 13, and a reference model that
// derives the expected operation list, result and done cycle from k and P.
// A single negedge process checks the DUT against that model on every cycle.
module tb_ecc_scalar_ctrl;
    localparam int WIDTH = 4;
    localparam int KBITS = 4;
    localparam int LAT   = 3;
    localparam int PR    = 13;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [KBITS-1:0] k = '0;
    logic [WIDTH-1:0] Px = '0;
    logic [WIDTH-1:0] Py = '0;
    logic             op_start;
    logic             op_dbl;
    logic [WIDTH-1:0] op_x1, op_y1, op_x2, op_y2;
    logic             op_done;
    logic [WIDTH-1:0] op_x, op_y;
    logic             op_inf;
    logic [WIDTH-1:0] kPx, kPy;
    logic             kP_inf, busy, done;

    logic             pu_done = 1'b0;
    logic             pu_inf = 1'b0;
    logic [WIDTH-1:0] pu_x = '0;
    logic [WIDTH-1:0] pu_y = '0;
    logic             inj_done = 1'b0;
    logic [WIDTH-1:0] inj_x = '0;
    logic [WIDTH-1:0] inj_y = '0;

    assign op_done = pu_done | inj_done;
    assign op_x    = inj_done ? inj_x : pu_x;
    assign op_y    = inj_done ? inj_y : pu_y;
    assign op_inf  = inj_done ? 1'b0 : pu_inf;

    ecc_scalar_ctrl #(.WIDTH(WIDTH), .KBITS(KBITS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .k(k), .Px(Px), .Py(Py),
        .op_start(op_start), .op_dbl(op_dbl),
        .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
        .op_done(op_done), .op_x(op_x), .op_y(op_y), .op_inf(op_inf),
        .kPx(kPx), .kPy(kPy), .kP_inf(kP_inf), .busy(busy), .done(done)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int md(input int v);
        return ((v % PR) + PR) % PR;
    endfunction

    function automatic int inv(input int a);
        int r;
        r = 0;
        for (int i = 1; i < PR; i++)
            if (md(md(a) * i) == 1) r = i;
        return r;
    endfunction

    // Affine point addition with infinity handling; equal points double.
    task automatic padd(input int x1, input int y1, input bit i1,
                        input int x2, input int y2, input bit i2,
                        output int x3, output int y3, output bit i3);
        int l;
        x3 = 0; y3 = 0; i3 = 1'b0;
        if (i1) begin
            x3 = x2; y3 = y2; i3 = i2;
        end else if (i2) begin
            x3 = x1; y3 = y1; i3 = i1;
        end else if (x1 == x2 && md(y1 + y2) == 0) begin
            i3 = 1'b1;
        end else begin
            if (x1 == x2) l = md((3 * x1 * x1 + 2) * inv(2 * y1));
            else          l = md((y2 - y1) * inv(x2 - x1));
            x3 = md(l * l - x1 - x2);
            y3 = md(l * (x1 - x3) - y1);
        end
    endtask

    // kP by k-fold repeated addition, independent of the bit walk.
    task automatic mult_rep(input int kk, input int px, input int py,
                            output int rx, output int ry, output bit ri);
        int tx, ty;
        bit ti;
        rx = 0; ry = 0; ri = 1'b1;
        for (int i = 0; i < kk; i++) begin
            padd(rx, ry, ri, px, py, 1'b0, tx, ty, ti);
            rx = tx; ry = ty; ri = ti;
        end
        if (ri) begin rx = 0; ry = 0; end
    endtask

    // Reference model outputs for the current run.
    int m_dbl [8];
    int m_x1 [8];
    int m_y1 [8];
    int m_n = 0;
    int m_kx = 0, m_ky = 0;
    bit m_kinf = 1'b0;
    int m_done_cyc = 0;
    int m_force = -1;

    // MSB-first double-and-add at point level; fidx forces infinity on that op.
    task automatic model_run(input int kk, input int px, input int py, input int fidx);
        int rx, ry, tx, ty;
        bit ri, ti;
        rx = 0; ry = 0; ri = 1'b1; m_n = 0;
        for (int b = KBITS - 1; b >= 0; b--) begin
            if (!ri) begin
                m_dbl[m_n] = 1; m_x1[m_n] = rx; m_y1[m_n] = ry;
                padd(rx, ry, 1'b0, rx, ry, 1'b0, tx, ty, ti);
                if (m_n == fidx) ti = 1'b1;
                rx = tx; ry = ty; ri = ti; m_n++;
            end
            if (kk[b]) begin
                if (ri) begin
                    rx = px; ry = py; ri = 1'b0;
                end else begin
                    m_dbl[m_n] = 0; m_x1[m_n] = rx; m_y1[m_n] = ry;
                    padd(rx, ry, 1'b0, px, py, 1'b0, tx, ty, ti);
                    if (m_n == fidx) ti = 1'b1;
                    rx = tx; ry = ty; ri = ti; m_n++;
                end
            end
        end
        m_kinf = ri;
        m_kx = ri ? 0 : rx;
        m_ky = ri ? 0 : ry;
        m_done_cyc = 3 * KBITS + 1 + LAT * m_n;
    endtask

    // Monitor and point-unit state.
    bit          m_active = 1'b0;
    int          run_cyc = 0;
    int          run_op_n = 0;
    int          force_idx = -1;
    int          pending = 0;
    int          pend0;
    bit          stab_on = 1'b0;
    int          cap_x1, cap_y1, cap_x2, cap_y2;
    int          res_x, res_y;
    bit          res_inf;
    int          tx, ty;
    bit          ti;
    int          h_kx = 0, h_ky = 0;
    bit          h_kinf = 1'b0;
    int          done_count = 0;
    int          last_done_cyc = 0, last_nops = 0;
    logic [15:0] seq = '0, last_seq = '0;
    logic [WIDTH-1:0] last_kx = '0, last_ky = '0;
    logic        last_kinf = 1'b0;

    // Every-cycle compare against the model, plus the latency-3 point unit.
    always @(negedge i_clk) begin
        pend0 = pending;
        pu_done = 1'b0;
        chk("busy", busy, m_active);
        chk("done", done, m_active && run_cyc == m_done_cyc);
        if (!m_active) chk("op_start_idle", op_start, 1'b0);
        if (done) begin
            last_done_cyc = run_cyc; last_nops = run_op_n; last_seq = seq;
            last_kx = kPx; last_ky = kPy; last_kinf = kP_inf;
            if (m_active && run_cyc == m_done_cyc) begin
                chk("kPx", kPx, m_kx);
                chk("kPy", kPy, m_ky);
                chk("kP_inf", kP_inf, m_kinf);
                chk("ops_issued", run_op_n, m_n);
            end
            done_count++;
        end else if (!m_active) begin
            chk("kPx_held", kPx, h_kx);
            chk("kPy_held", kPy, h_ky);
            chk("kP_inf_held", kP_inf, h_kinf);
        end
        if (pend0 > 0) begin
            if (stab_on) begin
                chk("op_x1_stable", op_x1, cap_x1);
                chk("op_y1_stable", op_y1, cap_y1);
                chk("op_x2_stable", op_x2, cap_x2);
                chk("op_y2_stable", op_y2, cap_y2);
            end
            pending = pend0 - 1;
            if (pending == 0) begin
                pu_done = 1'b1; pu_x = res_x[3:0]; pu_y = res_y[3:0]; pu_inf = res_inf;
            end
        end
        if (op_start) begin
            chk("op_start_legal", m_active && pend0 == 0 && run_op_n < m_n, 1'b1);
            if (run_op_n < m_n && run_op_n < 8) begin
                chk("op_dbl", op_dbl, m_dbl[run_op_n]);
                chk("op_x1", op_x1, m_x1[run_op_n]);
                chk("op_y1", op_y1, m_y1[run_op_n]);
            end
            chk("op_x2", op_x2, Px);
            chk("op_y2", op_y2, Py);
            cap_x1 = op_x1; cap_y1 = op_y1; cap_x2 = op_x2; cap_y2 = op_y2;
            if (op_dbl) padd(cap_x1, cap_y1, 1'b0, cap_x1, cap_y1, 1'b0, tx, ty, ti);
            else        padd(cap_x1, cap_y1, 1'b0, cap_x2, cap_y2, 1'b0, tx, ty, ti);
            if (run_op_n == m_force) ti = 1'b1;
            res_inf = ti;
            res_x = ti ? int'($urandom_range(1, 15)) : tx;
            res_y = ti ? int'($urandom_range(1, 15)) : ty;
            pending = LAT; stab_on = 1'b1;
            seq = {seq[14:0], op_dbl};
            run_op_n++;
        end
        if (i_rst) begin
            m_active = 1'b0; stab_on = 1'b0;
            h_kx = 0; h_ky = 0; h_kinf = 1'b0;
        end else if (m_active) begin
            if (run_cyc == m_done_cyc) begin
                m_active = 1'b0;
                h_kx = m_kx; h_ky = m_ky; h_kinf = m_kinf;
            end else begin
                run_cyc++;
            end
        end else if (i_start) begin
            model_run(int'(k), int'(Px), int'(Py), force_idx);
            m_force = force_idx;
            m_active = 1'b1; run_cyc = 1; run_op_n = 0; seq = '0;
        end
    end

    task automatic wait_done(input int dc0);
        int n;
        n = 0;
        while (done_count == dc0 && n < 300) begin
            @(posedge i_clk); #1; n++;
        end
        if (done_count == dc0) begin
            checks++; failures++;
            $display("FAIL run_timeout: got no done after %0d cycles, required done", n);
        end
    endtask

    task automatic run_one(input int kk, input int px, input int py, input int fi);
        int dc0;
        k = kk[3:0]; Px = px[3:0]; Py = py[3:0]; force_idx = fi;
        dc0 = done_count;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(dc0);
    endtask

    int pts_x [$];
    int pts_y [$];
    int ex, ey, dc0, n, kk, pi;
    bit ei;

    // Directed scenarios followed by randomized runs.
    initial begin
        for (int x = 0; x < PR; x++)
            for (int y = 0; y < PR; y++)
                if (md(y * y) == md(x * x * x + 2 * x + 3)) begin
                    pts_x.push_back(x); pts_y.push_back(y);
                end

        // Pin the reference arithmetic with hand-computed values.
        padd(3, 6, 1'b0, 3, 6, 1'b0, ex, ey, ei);
        chk("pin_2P_x", ex, 3); chk("pin_2P_y", ey, 7); chk("pin_2P_inf", ei, 0);
        mult_rep(3, 3, 6, ex, ey, ei);
        chk("pin_3P_inf", ei, 1);
        model_run(11, 3, 6, -1);
        chk("pin_11P_x", m_kx, 3); chk("pin_11P_y", m_ky, 7); chk("pin_11P_ops", m_n, 5);
        chk("pin_11P_cyc", m_done_cyc, 28);
        m_n = 0; m_done_cyc = 0;

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("rst_busy", busy, 0); chk("rst_op_start", op_start, 0);
        chk("rst_op_dbl", op_dbl, 0); chk("rst_done", done, 0);
        chk("rst_kPx", kPx, 0); chk("rst_kPy", kPy, 0); chk("rst_kP_inf", kP_inf, 0);
        @(posedge i_clk); #1;

        run_one(0, 3, 6, -1);
        chk("k0_cyc", last_done_cyc, 13); chk("k0_ops", last_nops, 0);
        chk("k0_inf", last_kinf, 1); chk("k0_x", last_kx, 0); chk("k0_y", last_ky, 0);

        run_one(1, 3, 6, -1);
        chk("k1_cyc", last_done_cyc, 13); chk("k1_ops", last_nops, 0);
        chk("k1_inf", last_kinf, 0); chk("k1_x", last_kx, 3); chk("k1_y", last_ky, 6);

        run_one(11, 3, 6, -1);
        chk("k11_seq", last_seq, 16'b11010); chk("k11_ops", last_nops, 5);
        chk("k11_cyc", last_done_cyc, 28);
        chk("k11_x", last_kx, 3); chk("k11_y", last_ky, 7); chk("k11_inf", last_kinf, 0);

        run_one(3, 3, 6, -1);
        chk("k3_inf", last_kinf, 1); chk("k3_x", last_kx, 0); chk("k3_y", last_ky, 0);
        chk("k3_cyc", last_done_cyc, 19);

        // Forced infinity on the bit-1 add: bit-0 double skipped, add reloads P.
        run_one(11, 3, 6, 2);
        chk("force_seq", last_seq, 16'b110); chk("force_ops", last_nops, 3);
        chk("force_cyc", last_done_cyc, 22);
        chk("force_x", last_kx, 3); chk("force_y", last_ky, 6); chk("force_inf", last_kinf, 0);

        // Reset pulse during ADD_WAIT of a k=15 run.
        force_idx = -1; k = 4'b1111; Px = 4'd3; Py = 4'd6;
        dc0 = done_count;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        n = 0;
        while (run_op_n < 2 && n < 100) begin @(posedge i_clk); #1; n++; end
        chk("rst_run_reached_add", run_op_n, 2);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("abort_busy", busy, 0); chk("abort_op_start", op_start, 0);
        repeat (5) @(posedge i_clk);
        #1;
        chk("abort_no_done", done_count, dc0);
        run_one(2, 3, 6, -1);
        chk("k2_x", last_kx, 3); chk("k2_y", last_ky, 7); chk("k2_inf", last_kinf, 0);

        // i_start held high, spurious op_done while R is infinity.
        force_idx = -1; k = 4'b0110; Px = 4'd3; Py = 4'd6;
        dc0 = done_count;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        inj_x = 4'd5; inj_y = 4'd9; inj_done = 1'b1;
        @(posedge i_clk); #1;
        inj_done = 1'b0;
        wait_done(dc0);
        chk("hold_one_done", done_count, dc0 + 1);
        chk("k6_inf", last_kinf, 1); chk("k6_x", last_kx, 0); chk("k6_y", last_ky, 0);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("rerun_accepted", busy, 1);
        wait_done(dc0 + 1);
        chk("rerun_done", done_count, dc0 + 2);
        chk("k6b_inf", last_kinf, 1);

        // Randomized runs; each result also checked against repeated addition.
        for (int r = 0; r < 12; r++) begin
            kk = int'($urandom_range(0, 15));
            pi = int'($urandom_range(0, pts_x.size() - 1));
            run_one(kk, pts_x[pi], pts_y[pi], -1);
            mult_rep(kk, pts_x[pi], pts_y[pi], ex, ey, ei);
            chk("rand_x", last_kx, ex); chk("rand_y", last_ky, ey); chk("rand_inf", last_kinf, ei);
        end

        repeat (4) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_ctrl.md
# ecc_scalar_ctrl

Double-and-add sequencer for the ECC scalar-multiplication top level. Latches a scalar k and base point P, then drives an external point-arithmetic unit (point double / point add over GF(prime)) through a start/done handshake, MSB-first, to produce kP. It owns the accumulator point R and the point-at-infinity flag. The arithmetic unit owns all field math, including the R==P and R==-P special cases.

## Interface
Parameters:
- WIDTH, 4, field-element width (Px, Py, kPx, kPy, op operands)
- KBITS, 4, scalar width

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request; sampled only in IDLE
- k  in  KBITS  scalar, latched on accepted i_start
- Px, Py  in  WIDTH  base point, latched on accepted i_start
- op_start  out  1  one-cycle pulse launching one arithmetic-unit operation
- op_dbl  out  1  1 = double (x1,y1); 0 = add (x1,y1)+(x2,y2); valid while op_start=1
- op_x1, op_y1  out  WIDTH  accumulator R
- op_x2, op_y2  out  WIDTH  latched P
- op_done  in  1  one-cycle pulse: the result is valid
- op_x, op_y  in  WIDTH  operation result
- op_inf  in  1  the result is the point at infinity; valid with op_done
- kPx, kPy  out  WIDTH  result, held from DONE until the next accepted start
- kP_inf  out  1  the result is infinity
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE

## Operation
- Registers: ks, Ps (latched inputs); Rx, Ry, R_inf; idx (counts from KBITS-1 down to 0).
- IDLE:
  - On i_start, latch k, Px and Py.
  - Set R_inf=1 and idx=KBITS-1.
  - Go to DBL.
- DBL:
  - If R_inf, go to ADD; no operation is issued.
  - Otherwise pulse op_start with op_dbl=1 and go to DBL_WAIT.
- DBL_WAIT:
  - On op_done, set Rx,Ry ← op_x,op_y and R_inf ← op_inf.
  - Go to ADD.
- ADD:
  - If ks[idx]=0, go to NEXT.
  - Else if R_inf, set R ← Ps and R_inf ← 0, then go to NEXT; no operation is issued.
  - Else pulse op_start with op_dbl=0 and go to ADD_WAIT.
- ADD_WAIT:
  - On op_done, capture the result as in DBL_WAIT.
  - Go to NEXT.
- NEXT:
  - If idx==0, go to DONE.
  - Otherwise decrement idx and go to DBL.
- DONE:
  - done=1.
  - kPx,kPy ← Rx,Ry, or 0,0 if R_inf; kP_inf ← R_inf.
  - Go to IDLE.
- At most one operation is outstanding at any time. op_start is never asserted while in a *_WAIT state.
- op_done outside *_WAIT is ignored; no register changes.
- i_start outside IDLE is ignored. The latched operands are unaffected.
- op_x1/op_y1/op_x2/op_y2 are driven straight from the registers and are stable from the op_start cycle through op_done.
- k=0 yields kP_inf=1 and kPx=kPy=0.

## Timing
- Reset values: state IDLE, op_start=0, op_dbl=0, done=0, busy=0, kPx=kPy=0, kP_inf=0, R_inf=1, idx=KBITS-1.
- Reset during any state, including *_WAIT, aborts the run:
  - return to IDLE the next cycle;
  - a late op_done is ignored;
  - no done pulse is produced.
- op_start asserts in the cycle immediately after entering DBL or ADD (Moore output, one cycle wide).
- The arithmetic unit's latency L is ≥1 cycle, measured from the op_start cycle to the op_done cycle. Each issued operation adds L cycles in a *_WAIT state.
- Done timing with no operations issued (k=0): done is high in cycle 3·KBITS+1 after the start-sampling edge, i.e. cycle 13 for KBITS=4.
- General done cycle = 3·KBITS + 1 + Σ(L over issued operations).
- A new i_start may be accepted in the cycle after done (IDLE).

## Test plan
- Bench uses a behavioural point unit with L=3 over y²=x³+2x+3 mod 13.
- k=0, P=(3,6) -> zero op_start pulses; done in cycle 13; kP_inf=1, kPx=kPy=0.
- k=1, P=(3,6) -> zero op_start pulses; done in cycle 13; kP=(3,6), kP_inf=0.
- k=4'b1011, P=(3,6) -> operation order exactly dbl,dbl,add,dbl,add; done in cycle 13+5·3=28; kP equals the model's 11P.
- k=order of P (model forces op_inf=1 on the final add) -> kP_inf=1 with kPx=kPy=0. Variant with the model forcing op_inf mid-run: the next DBL issues no op_start and the following add step loads R←P.
- i_rst pulsed for one cycle during ADD_WAIT of a k=4'b1111 run -> busy=0 and op_start=0 next cycle; the stale op_done is ignored; no done pulse. A fresh start with k=2 then yields 2P correctly.
- i_start held high throughout a k=4'b0110 run, and a spurious op_done injected in DBL with R_inf=1 -> both ignored; exactly one done; the result equals 6P. A second run is accepted in the cycle after done.
